// File: rtl/ddr4_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_pkg
// Shared definitions for the DDR4 host request path and ddr4_cont.
//   CA_W       : command address width ([30:29] bank group, [28:27] bank,
//                [26:0] row/column)
//   DQ_W       : data width of one read/write beat
//   q_state_t  : command-queue replay FSM states
//   req_t      : one queued host request {wr, addr, wdat}
// ---------------------------------------------------------------------------
package ddr4_pkg;

  localparam int CA_W = 31;
  localparam int DQ_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } q_state_t;

  typedef struct packed {
    logic            wr;
    logic [CA_W-1:0] addr;
    logic [DQ_W-1:0] wdat;
  } req_t;

endpackage

// File: rtl/ddr4_sync_fifo.sv
// ---------------------------------------------------------------------------
// ddr4_sync_fifo
// Single-clock FIFO of req_t entries with first-word-fall-through output.
//   i_clk    : clock
//   i_srst   : synchronous active-high reset (flushes pointers and count)
//   i_push   : write i_din (ignored when full)
//   i_din    : entry to write
//   i_pop    : discard the head entry (ignored when empty)
//   o_dout   : current head entry, valid while o_empty = 0
//   o_full   : o_count == DEPTH
//   o_empty  : o_count == 0
//   o_count  : registered occupancy
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module ddr4_sync_fifo
  import ddr4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  req_t             i_din,
  input  logic             i_pop,
  output req_t             o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_cmd_queue.sv
// ---------------------------------------------------------------------------
// ddr4_cmd_queue
// Host request queue upstream of ddr4_cont. Buffers read/write requests and
// replays each one as a level-held crd/cwr for HOLD_CYC cycles, followed by
// GAP_CYC idle cycles. Read data is sampled from crdat inside the hold window
// and returned to the host as a one-cycle rvalid pulse.
//   clkin  : clock
//   crst   : synchronous active-high reset (flushes queue, aborts command)
//   hvalid/hready/hwr/haddr/hwdat : host request handshake and payload
//   rvalid/rdat : read response pulse and data
//   crd/cwr/ca/cwdat : command to ddr4_cont (registered)
//   crdat  : read data from ddr4_cont
//   qlevel : queue occupancy (registered)
// ---------------------------------------------------------------------------
module ddr4_cmd_queue
  import ddr4_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 30,
  parameter int GAP_CYC  = 2,
  parameter int RD_LAT   = 20,
  parameter int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clkin,
  input  logic             crst,
  input  logic             hvalid,
  output logic             hready,
  input  logic             hwr,
  input  logic [CA_W-1:0]  haddr,
  input  logic [DQ_W-1:0]  hwdat,
  output logic             rvalid,
  output logic [DQ_W-1:0]  rdat,
  output logic             crd,
  output logic             cwr,
  output logic [CA_W-1:0]  ca,
  output logic [DQ_W-1:0]  cwdat,
  input  logic [DQ_W-1:0]  crdat,
  output logic [LVL_W-1:0] qlevel
);

  localparam int TMR_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Timer value seen during the ISSUE cycle whose 1-based index is RD_LAT.
  localparam logic [TMR_W-1:0] CAP_TMR = TMR_W'(HOLD_CYC - RD_LAT);

  q_state_t         r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_crd;
  logic             r_cwr;
  logic [CA_W-1:0]  r_ca;
  logic [DQ_W-1:0]  r_cwdat;
  logic [DQ_W-1:0]  r_rdat;
  logic             r_rvalid;
  logic             r_rd_pend;

  req_t             w_din;
  req_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_count;

  // Ready looks only at the registered count, so a full queue refuses a
  // push even in a cycle where the FSM is popping.
  assign hready = !crst && !w_full;
  assign w_push = hvalid && hready;
  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_din  = '{wr: hwr, addr: haddr, wdat: hwdat};

  ddr4_sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (LVL_W)
  ) u_fifo (
    .i_clk   (clkin),
    .i_srst  (crst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clkin) begin
    if (crst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_crd     <= 1'b0;
      r_cwr     <= 1'b0;
      r_ca      <= '0;
      r_cwdat   <= '0;
      r_rdat    <= '0;
      r_rvalid  <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      // The capture edge arms r_rd_pend; the pulse appears one cycle later.
      r_rvalid  <= r_rd_pend;
      r_rd_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_crd   <= !w_head.wr;
            r_cwr   <= w_head.wr;
            r_ca    <= w_head.addr;
            r_cwdat <= w_head.wdat;
            r_timer <= TMR_W'(HOLD_CYC - 1);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // r_crd is high for the whole window of a read, so it doubles as
          // the "this command is a read" flag.
          if (r_crd && (r_timer == CAP_TMR)) begin
            r_rdat    <= crdat;
            r_rd_pend <= 1'b1;
          end
          if (r_timer == '0) begin
            r_crd   <= 1'b0;
            r_cwr   <= 1'b0;
            r_timer <= TMR_W'(GAP_CYC - 1);
            r_state <= GAP;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        GAP: begin
          // ca/cwdat keep their last values through the gap.
          if (r_timer == '0) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign crd    = r_crd;
  assign cwr    = r_cwr;
  assign ca     = r_ca;
  assign cwdat  = r_cwdat;
  assign rdat   = r_rdat;
  assign rvalid = r_rvalid;
  assign qlevel = w_count;

endmodule

// File: doc/ddr4_cmd_queue.md
# ddr4_cmd_queue

Host-side request queue sitting directly upstream of `ddr4_cont`. Accepts read/write requests over a valid/ready handshake, buffers them in a small FIFO, and replays each one to the controller as level-held `crd`/`cwr`/`ca`/`cwdat` for a fixed window. For reads, it samples `crdat` at a fixed latency and returns it to the host as a one-cycle response pulse.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD_CYC`, 30: cycles each command is held on `crd`/`cwr` (600 ns at 20 ns `clkin`).
- `GAP_CYC`, 2: cycles with `crd`=`cwr`=0 after each hold window.
- `RD_LAT`, 20: cycle index within the hold window at which `crdat` is sampled; 1 ≤ `RD_LAT` ≤ `HOLD_CYC`.

Ports:
- `clkin` in 1: single clock for the block.
- `crst` in 1: reset, synchronous, active-high.
- `hvalid` in 1: host request valid.
- `hready` out 1: queue can accept a request.
- `hwr` in 1: 1 = write, 0 = read.
- `haddr` in 31: request address; same format as `ca`, i.e. [30:29] bank group, [28:27] bank, [26:0] row/column.
- `hwdat` in 4: write data.
- `rvalid` out 1: read-response pulse.
- `rdat` out 4: read data, valid when `rvalid`=1.
- `crd` out 1: read command to `ddr4_cont`.
- `cwr` out 1: write command to `ddr4_cont`.
- `ca` out 31: address to `ddr4_cont`.
- `cwdat` out 4: write data to `ddr4_cont`.
- `crdat` in 4: read data from `ddr4_cont`.
- `qlevel` out $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Push.** A request is accepted on a rising edge with `hvalid`=1 and `hready`=1. The entry stored is {`hwr`, `haddr`, `hwdat`}.
- **Ready.** `hready` = !`crst` && (`qlevel` != `DEPTH`). It is combinational from the registered count only, so a push is refused when full even if a pop occurs in the same cycle.
- **Simultaneous push and pop** (not full): `qlevel` is unchanged, and FIFO order is preserved.
- **Pointers.** Read and write pointers wrap modulo `DEPTH`.

FSM states are IDLE, ISSUE and GAP:
- **IDLE:** all command outputs low. If `qlevel`>0, pop the head into the issue register, load timer = `HOLD_CYC`-1, and go to ISSUE.
- **ISSUE:** `crd` = !wr, `cwr` = wr, with `ca`/`cwdat` taken from the issue register.
  - Exactly one of `crd`/`cwr` is high.
  - When timer = 0, load timer = `GAP_CYC`-1 and go to GAP. Otherwise decrement.
- **GAP:** `crd`=`cwr`=0; `ca`/`cwdat` hold their last values. When timer = 0, go to IDLE.
- **Read return.** For a read, `crdat` is registered into `rdat` when ISSUE cycle index (1-based) = `RD_LAT`. `rvalid` pulses high in the following cycle. There is one response per read and none for writes.
- **Read order.** Responses are returned in request order. At most one command is in flight.

## Timing
- **Registered outputs.** `crd`, `cwr`, `ca`, `cwdat`, `rvalid`, `rdat` and `qlevel` are all registered.
- **Reset values.** `crd`=`cwr`=0, `ca`=0, `cwdat`=0, `rvalid`=0, `rdat`=0, `qlevel`=0, FSM=IDLE. `hready`=0 while `crst`=1.
- **Issue latency.** With the queue empty, a push at edge N gives `qlevel`=1 after N. IDLE pops at edge N+1, and `crd`/`cwr` rise after edge N+1 and stay high exactly `HOLD_CYC` cycles.
- **Back-to-back period.** Command period is `HOLD_CYC`+`GAP_CYC`+1 cycles (one IDLE cycle minimum).
- **Read response.** `rvalid` is asserted `RD_LAT`+1 cycles after the first cycle `crd` is high.
- **Reset mid-operation.** At the next edge, `crd`/`cwr` drop, the FIFO is flushed, and any pending `rvalid` is suppressed. No response is ever produced for a flushed or interrupted request.
- **Host stall.** `hvalid` held with `hready`=0 must be accepted on the first edge after `hready` rises.

## Structure
- **Package `ddr4_pkg`.** Holds `CA_W`=31 and `DQ_W`=4, the `q_state_t` enum (IDLE, ISSUE, GAP), and the `req_t` struct {wr, addr, wdat}. It is shared with `ddr4_cont` for address and data widths.
- **Sub-module `ddr4_sync_fifo`.** A parameterized single-clock FIFO of `req_t` with `push`, `pop`, `full`, `empty` and `count`. The FSM, timer and read-capture logic stay in `ddr4_cmd_queue`.

## Test plan
- **Reset:** hold `crst`=1 for 3 cycles → all outputs 0 and `hready`=0. After release, `hready`=1 and `qlevel`=0.
- **Single write:** push `hwr`=1, `haddr`={2'b00,2'b11,27'd3193}, `hwdat`=4'hA → `cwr` high for exactly 30 cycles with `ca`=that address and `cwdat`=4'hA. `crd` stays 0 and `rvalid` never pulses.
- **Single read:** push `hwr`=0, `haddr`={2'b01,2'b11,27'd3193}, with `crdat` driven 4'h5 → `crd` high 30 cycles and `rvalid`=1 for one cycle, 21 cycles after `crd` rises, with `rdat`=4'h5.
- **Full:** push 5 requests back-to-back while the first is in ISSUE → `qlevel` reaches 4 and `hready`=0. The 5th request is held and accepted on the edge after the first pop that frees a slot. The `crd`/`cwr` rising edges are spaced 33 cycles apart.
- **Simultaneous push/pop:** with `qlevel`=1, push in the IDLE pop cycle → `qlevel` stays 1 and both commands issue in order.
- **Reset mid-read:** assert `crst` at ISSUE cycle 10 of a read → `crd`=0 next cycle, no `rvalid`, and `qlevel`=0.
